// File: rtl/if_id_skid_register_if.sv
// Fetch/decode handshake bundle for the two-entry IF/ID skid register.
// The slave modport is the register; the master modport is its environment.
interface if_id_skid_register_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 32
);
  logic               if_valid;
  logic               if_ready;
  logic [ADDR_W-1:0]  if_pc;
  logic [INSTR_W-1:0] if_instr;
  logic               flush;
  logic               id_valid;
  logic               id_ready;
  logic [ADDR_W-1:0]  id_pc;
  logic [INSTR_W-1:0] id_instr;
  logic [ADDR_W-1:0]  id_pc_plus4;

  modport master (
    output if_valid, if_pc, if_instr, flush, id_ready,
    input  if_ready, id_valid, id_pc, id_instr, id_pc_plus4
  );

  modport slave (
    input  if_valid, if_pc, if_instr, flush, id_ready,
    output if_ready, id_valid, id_pc, id_instr, id_pc_plus4
  );
endinterface

// File: rtl/if_id_skid_register.sv
// Two-entry IF/ID pipeline register (main + skid) with valid/ready handshake and flush.
// Optional macro IFID_NOP_INJECT_EN: a flush loads an explicit NOP instead of a bubble.
module if_id_skid_register #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 32
`ifdef IFID_NOP_INJECT_EN
  ,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h00000013)
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  if_id_skid_register_if.slave  bus
);

  logic               main_v_q, main_v_d;
  logic [ADDR_W-1:0]  main_pc_q, main_pc_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d;
  logic               skid_v_q, skid_v_d;
  logic [ADDR_W-1:0]  skid_pc_q, skid_pc_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;

  logic if_ready;
  logic accept;
  logic main_free;

  // if_ready depends only on state (and reset), never on id_ready
  assign if_ready  = ~skid_v_q & ~rst;
  assign accept    = bus.if_valid & if_ready;
  assign main_free = ~main_v_q | bus.id_ready;

  always_comb begin
    main_v_d     = main_v_q;
    main_pc_d    = main_pc_q;
    main_instr_d = main_instr_q;
    skid_v_d     = skid_v_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;

    if (bus.flush) begin
`ifdef IFID_NOP_INJECT_EN
      main_v_d     = 1'b1;
      main_instr_d = NOP_INSTR;
      main_pc_d    = main_v_q ? main_pc_q : '0;
`else
      main_v_d     = 1'b0;
`endif
    end else if (main_free) begin
      if (skid_v_q) begin
        main_v_d     = 1'b1;
        main_pc_d    = skid_pc_q;
        main_instr_d = skid_instr_q;
      end else if (accept) begin
        main_v_d     = 1'b1;
        main_pc_d    = bus.if_pc;
        main_instr_d = bus.if_instr;
      end else begin
        main_v_d     = 1'b0;
      end
    end

    // accept implies skid is empty, so loading the skid never overwrites a live pair
    if (bus.flush) begin
      skid_v_d = 1'b0;
    end else if (!main_free && accept) begin
      skid_v_d     = 1'b1;
      skid_pc_d    = bus.if_pc;
      skid_instr_d = bus.if_instr;
    end else if (main_free && skid_v_q) begin
      skid_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_v_q     <= 1'b0;
      main_pc_q    <= '0;
      main_instr_q <= '0;
      skid_v_q     <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
    end else begin
      main_v_q     <= main_v_d;
      main_pc_q    <= main_pc_d;
      main_instr_q <= main_instr_d;
      skid_v_q     <= skid_v_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  assign bus.if_ready    = if_ready;
  assign bus.id_valid    = main_v_q;
  assign bus.id_pc       = main_pc_q;
  assign bus.id_instr    = main_instr_q;
  assign bus.id_pc_plus4 = main_pc_q + ADDR_W'(4);

endmodule

// File: tb/tb_if_id_skid_register.sv
// Bench for if_id_skid_register: hand-derived vector table plus a queue-based
// reference scoreboard checked every cycle, and a reset-while-full sequence.
module tb_if_id_skid_register;
  localparam int unsigned AW = 8;
  localparam int unsigned IW = 32;
`ifdef IFID_NOP_INJECT_EN
  localparam bit NOP_EN = 1'b1;
`else
  localparam bit NOP_EN = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_id_skid_register_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();
  if_id_skid_register #(.ADDR_W(AW), .INSTR_W(IW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [7:0]  pc;
    logic [31:0] instr;
  } pair_t;

  typedef struct {
    logic        v;
    logic [7:0]  pc;
    logic [31:0] instr;
    logic        fl;
    logic        rdy;
    logic        e_valid;
    logic [7:0]  e_pc;
    logic [31:0] e_instr;
    logic        e_rdy;
  } vec_t;

  pair_t       sb[$];
  logic [7:0]  m_pc;
  logic [31:0] m_instr;
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_pc    = '0;
    m_instr = '0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " sb id_valid"}, 32'(bus.id_valid), 32'(sb.size() > 0));
    chk({tag, " sb if_ready"}, 32'(bus.if_ready), 32'(sb.size() < 2));
    chk({tag, " sb id_pc"}, 32'(bus.id_pc), 32'(m_pc));
    chk({tag, " sb id_instr"}, bus.id_instr, m_instr);
    chk({tag, " sb id_pc_plus4"}, 32'(bus.id_pc_plus4), 32'(8'(m_pc + 8'd4)));
  endtask

  task automatic step(input logic v, input logic [7:0] pc, input logic [31:0] instr,
                      input logic fl, input logic rdy, input string tag);
    bit    acc;
    pair_t p;
    logic [7:0] npc;
    bus.if_valid = v;
    bus.if_pc    = pc;
    bus.if_instr = instr;
    bus.flush    = fl;
    bus.id_ready = rdy;
    acc = v && (sb.size() < 2);
    @(posedge clk);
    if (fl) begin
      npc = (sb.size() > 0) ? sb[0].pc : 8'd0;
      sb.delete();
      if (NOP_EN) begin
        p.pc = npc; p.instr = NOP;
        sb.push_back(p);
      end
    end else begin
      if (rdy && sb.size() > 0) void'(sb.pop_front());
      if (acc) begin
        p.pc = pc; p.instr = instr;
        sb.push_back(p);
      end
    end
    if (sb.size() > 0) begin
      m_pc    = sb[0].pc;
      m_instr = sb[0].instr;
    end
    #1;
    check_model(tag);
  endtask

  vec_t tbl[19];

  function automatic vec_t mk(input logic v, input logic [7:0] pc, input logic [31:0] instr,
                              input logic fl, input logic rdy, input logic ev,
                              input logic [7:0] epc, input logic [31:0] ei, input logic er);
    vec_t t;
    t.v = v; t.pc = pc; t.instr = instr; t.fl = fl; t.rdy = rdy;
    t.e_valid = ev; t.e_pc = epc; t.e_instr = ei; t.e_rdy = er;
    return t;
  endfunction

  initial begin
    logic [31:0] nop_or_d0, nop_or_b3;
    logic [7:0]  ep4;
    logic [7:0]  rpc;

    nop_or_d0 = NOP_EN ? NOP : 32'hD0;
    nop_or_b3 = NOP_EN ? NOP : 32'hB3;
    // streaming
    tbl[0]  = mk(1'b1, 8'd0,   32'hA0, 1'b0, 1'b1, 1'b1, 8'd0,   32'hA0, 1'b1);
    tbl[1]  = mk(1'b1, 8'd4,   32'hA1, 1'b0, 1'b1, 1'b1, 8'd4,   32'hA1, 1'b1);
    tbl[2]  = mk(1'b1, 8'd8,   32'hA2, 1'b0, 1'b1, 1'b1, 8'd8,   32'hA2, 1'b1);
    tbl[3]  = mk(1'b1, 8'd12,  32'hA3, 1'b0, 1'b1, 1'b1, 8'd12,  32'hA3, 1'b1);
    tbl[4]  = mk(1'b0, 8'd0,   32'h0,  1'b0, 1'b1, 1'b0, 8'd12,  32'hA3, 1'b1);
    // back-pressure, PC 24 offered while full must be ignored
    tbl[5]  = mk(1'b1, 8'd16,  32'hB0, 1'b0, 1'b0, 1'b1, 8'd16,  32'hB0, 1'b1);
    tbl[6]  = mk(1'b1, 8'd20,  32'hB1, 1'b0, 1'b0, 1'b1, 8'd16,  32'hB0, 1'b0);
    tbl[7]  = mk(1'b1, 8'd24,  32'hB2, 1'b0, 1'b0, 1'b1, 8'd16,  32'hB0, 1'b0);
    tbl[8]  = mk(1'b0, 8'd0,   32'h0,  1'b0, 1'b1, 1'b1, 8'd20,  32'hB1, 1'b1);
    tbl[9]  = mk(1'b0, 8'd0,   32'h0,  1'b0, 1'b1, 1'b0, 8'd20,  32'hB1, 1'b1);
    // flush while full with PC 24 presented
    tbl[10] = mk(1'b1, 8'd16,  32'hD0, 1'b0, 1'b0, 1'b1, 8'd16,  32'hD0, 1'b1);
    tbl[11] = mk(1'b1, 8'd20,  32'hD1, 1'b0, 1'b0, 1'b1, 8'd16,  32'hD0, 1'b0);
    tbl[12] = mk(1'b1, 8'd24,  32'hD2, 1'b1, 1'b0, NOP_EN, 8'd16, nop_or_d0, 1'b1);
    tbl[13] = mk(1'b0, 8'd0,   32'h0,  1'b0, 1'b1, 1'b0, 8'd16,  nop_or_d0, 1'b1);
    // flush coinciding with a drain and an acceptable input
    tbl[14] = mk(1'b1, 8'd28,  32'hB3, 1'b0, 1'b1, 1'b1, 8'd28,  32'hB3, 1'b1);
    tbl[15] = mk(1'b1, 8'd32,  32'hB4, 1'b1, 1'b1, NOP_EN, 8'd28, nop_or_b3, 1'b1);
    tbl[16] = mk(1'b0, 8'd0,   32'h0,  1'b0, 1'b1, 1'b0, 8'd28,  nop_or_b3, 1'b1);
    // PC+4 wrap
    tbl[17] = mk(1'b1, 8'd252, 32'hC0, 1'b0, 1'b1, 1'b1, 8'd252, 32'hC0, 1'b1);
    tbl[18] = mk(1'b0, 8'd0,   32'h0,  1'b0, 1'b1, 1'b0, 8'd252, 32'hC0, 1'b1);

    rst = 1'b1;
    bus.if_valid = 1'b0; bus.if_pc = '0; bus.if_instr = '0;
    bus.flush = 1'b0; bus.id_ready = 1'b0;
    model_reset();
    #1;
    chk("reset id_valid", 32'(bus.id_valid), 32'd0);
    chk("reset if_ready", 32'(bus.if_ready), 32'd0);
    chk("reset id_pc", 32'(bus.id_pc), 32'd0);
    chk("reset id_instr", bus.id_instr, 32'd0);
    chk("reset id_pc_plus4", 32'(bus.id_pc_plus4), 32'd4);
    #6 rst = 1'b0;
    #1;
    chk("post-reset if_ready", 32'(bus.if_ready), 32'd1);

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].v, tbl[i].pc, tbl[i].instr, tbl[i].fl, tbl[i].rdy, $sformatf("vec%0d", i));
      ep4 = tbl[i].e_pc + 8'd4;
      chk($sformatf("vec%0d id_valid", i), 32'(bus.id_valid), 32'(tbl[i].e_valid));
      chk($sformatf("vec%0d id_pc", i), 32'(bus.id_pc), 32'(tbl[i].e_pc));
      chk($sformatf("vec%0d id_instr", i), bus.id_instr, tbl[i].e_instr);
      chk($sformatf("vec%0d if_ready", i), 32'(bus.if_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d id_pc_plus4", i), 32'(bus.id_pc_plus4), 32'(ep4));
    end

    // randomized traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      rpc = 8'($urandom_range(0, 63)) << 2;
      step($urandom_range(0, 3) != 0, rpc, $urandom, $urandom_range(0, 19) == 0,
           $urandom_range(0, 2) != 0, "rand");
    end

    // async reset while both entries are full
    step(1'b0, 8'd0, 32'h0, 1'b1, 1'b0, "pre-fill flush");
    step(1'b0, 8'd0, 32'h0, 1'b0, 1'b1, "pre-fill drain");
    step(1'b1, 8'd40, 32'hE0, 1'b0, 1'b0, "fill0");
    step(1'b1, 8'd44, 32'hE1, 1'b0, 1'b0, "fill1");
    chk("full if_ready", 32'(bus.if_ready), 32'd0);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("midrst id_valid", 32'(bus.id_valid), 32'd0);
    chk("midrst id_pc", 32'(bus.id_pc), 32'd0);
    chk("midrst id_instr", bus.id_instr, 32'd0);
    chk("midrst id_pc_plus4", 32'(bus.id_pc_plus4), 32'd4);
    chk("midrst if_ready", 32'(bus.if_ready), 32'd0);
    bus.if_valid = 1'b1; bus.if_pc = 8'd48; bus.id_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("inrst id_valid", 32'(bus.id_valid), 32'd0);
    chk("inrst if_ready", 32'(bus.if_ready), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("rst release if_ready", 32'(bus.if_ready), 32'd1);
    step(1'b0, 8'd0, 32'h0, 1'b0, 1'b1, "after rst idle");
    chk("no resurface id_valid", 32'(bus.id_valid), 32'd0);
    step(1'b1, 8'd60, 32'hF0, 1'b0, 1'b1, "after rst s0");
    step(1'b1, 8'd64, 32'hF1, 1'b0, 1'b1, "after rst s1");
    chk("after rst id_pc", 32'(bus.id_pc), 32'd64);
    step(1'b0, 8'd0, 32'h0, 1'b0, 1'b1, "after rst drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
